lc3_mem_arbiter: RTL
====================

Name: lc3_mem_arbiter

Overview:
- Shares the single-port main memory between two requesters: the LC-3 CPU control path (MAR/MDR memory port) and a device/DMA port (e.g. display refresh or loader).
- Performs round-robin arbitration and sequences a fixed-latency memory access.
- Returns a one-cycle ready pulse to the winning requester; the CPU pulse drives the control FSM's memRDY input.
- Sits between lc3 datapath/control and the memory model.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 2, cycles mem_en is held per access (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request, level, held until cpu_rdy.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address (MAR).
- cpu_wdata  in  DATA_W  CPU write data (MDR).
- cpu_rdata  out  DATA_W  last CPU read data.
- cpu_rdy  out  1  one-cycle completion pulse (memRDY).
- dev_req  in  1  device request, level.
- dev_we  in  1  device write enable.
- dev_addr  in  ADDR_W  device address.
- dev_wdata  in  DATA_W  device write data.
- dev_rdata  out  DATA_W  last device read data.
- dev_rdy  out  1  device completion pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle.
- gnt_dev  out  1  1 while the device owns the current access.
- busy  out  1  1 when state != ARB_IDLE.

Behaviour:
- Reset (async, immediate):
  - state = ARB_IDLE; all outputs 0; cpu_rdata and dev_rdata = 0.
  - last_gnt = GNT_DEV, so the CPU wins the first tie.
  - lat_cnt = 0.
- FSM states: ARB_IDLE, ARB_ACCESS, ARB_DONE.
- ARB_IDLE:
  - If no request is active, stay in ARB_IDLE.
  - If exactly one requester is active, grant it.
  - If both are active, grant the requester != last_gnt.
  - On the grant edge:
    - latch we, addr and wdata of the winner into internal registers;
    - set gnt_dev accordingly and update last_gnt;
    - lat_cnt = MEM_LAT-1;
    - go to ARB_ACCESS.
- ARB_ACCESS:
  - mem_en = 1; mem_addr, mem_wdata and mem_we come from the latched registers and stay stable for the whole state.
  - mem_we = latched we for every ACCESS cycle.
  - If lat_cnt != 0, decrement lat_cnt.
  - If lat_cnt == 0:
    - for a read, capture mem_rdata into the winner's rdata register;
    - go to ARB_DONE.
- ARB_DONE:
  - mem_en = 0, mem_we = 0.
  - Pulse the winner's rdy for exactly this cycle; its rdata is valid this cycle.
  - Next state is ARB_IDLE.
- Register and output rules:
  - rdata registers hold their value until the same requester's next read completes; writes leave them unchanged.
  - Latched address/data are used, so requester input changes after the grant have no effect on the access.
  - gnt_dev holds its value through ARB_IDLE until the next grant.
- Latency and throughput:
  - req high in cycle T while the arbiter is idle → ACCESS in cycles T+1..T+MEM_LAT → rdy in cycle T+MEM_LAT+1.
  - Maximum throughput is one access per MEM_LAT+2 cycles.
- Handshake:
  - A requester must deassert req in the cycle after its rdy. A req still high in ARB_IDLE is a new request.
  - A req that drops before its grant is simply dropped; no error.
- Fairness: with both requesters continuously requesting, grants alternate CPU, DEV, CPU, … Neither requester waits more than one foreign access.
- Reset mid-access: abort immediately. mem_en drops asynchronously, no rdy is issued, and the requester re-requests after reset.
- mem_* outputs are registered/decoded from the state only, with no combinational path from req inputs.

Decomposition:
- lc3Pkg additions:
  - typedef enum ArbStates {ARB_IDLE, ARB_ACCESS, ARB_DONE};
  - typedef enum logic {GNT_CPU, GNT_DEV} ArbGrant;
  - localparam default MEM_LAT.
- One sub-module: lc3_rr_pick2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Outputs: valid, gnt.
  - The top-level module holds the FSM, counter, latches and rdata registers.

Test Plan:
- Reset, then cpu_req=1, we=0, addr=x3000 with memory[x3000]=x1234, MEM_LAT=2:
  - mem_en is high in exactly 2 cycles with mem_addr=x3000;
  - cpu_rdy pulses once at T+3 with cpu_rdata=x1234;
  - dev_rdy stays 0.
- dev_req write of addr=xFE06, wdata=x0041:
  - mem_we=1 with mem_addr=xFE06 and mem_wdata=x0041 for both ACCESS cycles;
  - dev_rdy pulses once at T+3; dev_rdata is unchanged.
- cpu_req and dev_req both rise in the same cycle after reset and are re-raised after each rdy, for 4 accesses:
  - grant order is CPU, DEV, CPU, DEV;
  - gnt_dev reads 0, 1, 0, 1.
- Device holds its request; CPU changes cpu_addr from x3000 to x3001 mid-ACCESS:
  - mem_addr stays x3000 through the access;
  - the device is granted next.
- Assert rst during the first ACCESS cycle:
  - mem_en, busy and both rdy drop immediately;
  - after release the state is ARB_IDLE and a new CPU request completes normally.
- MEM_LAT=1:
  - a single ACCESS cycle; rdy arrives at T+2;
  - back-to-back CPU requests complete every 3 cycles.

Source files
------------

// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types for the LC-3 memory arbiter: FSM states, grant owner and latency defaults.
package lc3_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } ArbStates;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DEV = 1'b1
  } ArbGrant;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int LAT_CNT_W       = 4;

  function automatic ArbGrant otherGrant(input ArbGrant g);
    return (g == GNT_CPU) ? GNT_DEV : GNT_CPU;
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; a tie goes to the side that did not win last.
module lc3_rr_pick2
  import lc3_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  ArbGrant    last_gnt,
  output logic       valid,
  output ArbGrant    gnt
);

  always_comb begin
    valid = |req;
    gnt   = GNT_CPU;
    if (req == 2'b11) gnt = otherGrant(last_gnt);
    else if (req[1])  gnt = GNT_DEV;
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares single-port main memory between the LC-3 control path and a device/DMA port,
// running one fixed-latency access at a time with a one-cycle ready pulse to the winner.
//
// state      | meaning
// ARB_IDLE   | no access in flight; arbitrate on the current requests
// ARB_ACCESS | mem_en held MEM_LAT cycles from latched address/data
// ARB_DONE   | rdy pulse to the winner, its rdata valid
module lc3_mem_arbiter
  import lc3_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_rdy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_dev,
  output logic              busy
);

  ArbStates             state;
  ArbGrant              lastGnt;
  logic [LAT_CNT_W-1:0] latCnt;
  logic                 latWe;
  logic                 pickValid;
  ArbGrant              pickGnt;

  lc3_rr_pick2 uPick (
    .req      ({dev_req, cpu_req}),
    .last_gnt (lastGnt),
    .valid    (pickValid),
    .gnt      (pickGnt)
  );

  // mem_addr/mem_wdata are the latched winner registers, so requester changes after the grant are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      lastGnt   <= GNT_DEV;
      latCnt    <= '0;
      latWe     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
      cpu_rdy   <= 1'b0;
      dev_rdy   <= 1'b0;
      gnt_dev   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cpu_rdy <= 1'b0;
      dev_rdy <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pickValid) begin
            if (pickGnt == GNT_DEV) begin
              latWe     <= dev_we;
              mem_we    <= dev_we;
              mem_addr  <= dev_addr;
              mem_wdata <= dev_wdata;
            end else begin
              latWe     <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            gnt_dev <= (pickGnt == GNT_DEV);
            lastGnt <= pickGnt;
            latCnt  <= LAT_CNT_W'(MEM_LAT - 1);
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            state   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (latCnt != '0) begin
            latCnt <= latCnt - 1'b1;
          end else begin
            if (!latWe) begin
              if (gnt_dev) dev_rdata <= mem_rdata;
              else         cpu_rdata <= mem_rdata;
            end
            if (gnt_dev) dev_rdy <= 1'b1;
            else         cpu_rdy <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
